hdc_hamming_sched: RTL and testbench
====================================

// Module: hdc_hamming_sched
// PURPOSE
// - Sequences the ham/spam Hamming-distance classification of one DIM-bit HDC query hypervector.
// - Streams the query and both class prototypes out of external chunk memories, CHUNK bits per cycle.
// - Accumulates popcount(query ^ proto) per class and issues a registered ham/spam/tie decision.
// - Sits between the encoder's query buffer / prototype store and the downstream result consumer.
// PARAMETERS
// - DIM      10000                 hypervector width in bits; DIM % CHUNK == 0 (elaboration error otherwise)
// - CHUNK    100                   bits compared per cycle
// - N_CHK    DIM/CHUNK (100)       chunks per query (derived localparam)
// - ADDR_W   $clog2(N_CHK) (7)     chunk address width (derived)
// - CNT_W    $clog2(DIM+1) (14)    distance counter width (derived)
// PORTS
// - clk         in   1       single clock, rising edge
// - rst         in   1       asynchronous, active-high reset
// - start       in   1       request a classification; sampled only in IDLE
// - rd_en       out  1       chunk read strobe to query/prototype memories
// - chunk_addr  out  ADDR_W  chunk index for this read
// - q_chunk     in   CHUNK   query bits for the address read one cycle earlier
// - ham_chunk   in   CHUNK   ham prototype bits, same timing
// - spam_chunk  in   CHUNK   spam prototype bits, same timing
// - busy        out  1       high from start acceptance until done cycle inclusive
// - done        out  1       one-cycle pulse; result outputs updated this cycle
// - distHam     out  CNT_W   Hamming distance query vs ham prototype
// - distSpam    out  CNT_W   Hamming distance query vs spam prototype
// - hamSpam     out  2       signed decision: 2'b01 ham, 2'b11 spam (-1), 2'b00 tie
// BEHAVIOUR
// - Reset (async, immediate): state IDLE; rd_en, busy, done = 0; chunk_addr = 0; accumulators,
//   distHam, distSpam = 0; hamSpam = 2'b00. All outputs registered.
// - FSM IDLE -> RUN -> LAST -> RESULT -> IDLE.
//   IDLE: start=1 -> clear accumulators, busy=1, rd_en=1, chunk_addr=0, go RUN.
//   RUN: rd_en=1 every cycle, chunk_addr increments by 1; cycle after the read of N_CHK-1 -> LAST (rd_en=0).
//   LAST: accumulate final chunk only; go RESULT.
//   RESULT: latch distHam/distSpam, compute hamSpam, done=1 for one cycle; next cycle IDLE, busy=0.
// - Read latency fixed at 1: data returned on q/ham/spam_chunk is accumulated the cycle after its rd_en.
// - Per accumulate cycle: accH += popcount(q_chunk ^ ham_chunk); accS += popcount(q_chunk ^ spam_chunk);
//   popcount width $clog2(CHUNK+1); CNT_W is sufficient, no saturation/wrap possible.
// - Addresses 0..N_CHK-1 each issued exactly once, contiguous, no gaps; chunk_addr never exceeds N_CHK-1.
// - Latency: start sampled at edge T -> rd_en high T+1..T+N_CHK -> done at edge T+N_CHK+2 (102 at defaults).
// - Decision: distHam < distSpam -> 2'b01; distHam > distSpam -> 2'b11; equal -> 2'b00.
// - distHam, distSpam, hamSpam hold their values until the next RESULT cycle (not cleared by start).
// - start while busy (RUN/LAST/RESULT) ignored, no queuing; start held high continuously -> new run
//   accepted in the IDLE cycle following done (one idle cycle minimum between runs).
// - rst mid-run: aborts instantly, outputs to reset values; partial counts discarded, no done pulse.
// - q/ham/spam_chunk are don't-care when no read is outstanding; X there must not reach outputs.
// TESTING
// - query=random, ham=query, spam=~query -> distHam=0, distSpam=10000, hamSpam=01, done at T+102.
// - query=random, spam=query, ham=query with chunk 5 all-inverted -> distHam=100, distSpam=0, hamSpam=11.
// - ham differs only at bit 0 of chunk 0, spam only at bit 99 of chunk 99 -> both dists=1, hamSpam=00.
// - pulse start again at rd_en cycles 1 and 50 -> ignored; addresses 0..99 each exactly once, one done.
// - assert rst when chunk_addr=50 -> all outputs 0 same cycle; release, restart -> correct fresh result.
// - start held high for 3 runs with differing vectors -> done every 103 cycles, results hold between dones.

Source files
------------

// File: rtl/hdc_hamming_sched.sv
// rtl/hdc_hamming_sched.sv - ham/spam Hamming-distance scheduler for one HDC query hypervector.
// Streams query and prototypes chunk by chunk, accumulates per-class distances, issues a decision.
module hdc_hamming_sched #(
  parameter int DIM   = 10000,
  parameter int CHUNK = 100,
  localparam int N_CHK  = DIM / CHUNK,
  localparam int ADDR_W = $clog2(N_CHK),
  localparam int CNT_W  = $clog2(DIM + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              rd_en,
  output logic [ADDR_W-1:0] chunk_addr,
  input  logic [CHUNK-1:0]  q_chunk,
  input  logic [CHUNK-1:0]  ham_chunk,
  input  logic [CHUNK-1:0]  spam_chunk,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  distHam,
  output logic [CNT_W-1:0]  distSpam,
  output logic [1:0]        hamSpam
);

  localparam int PC_W = $clog2(CHUNK + 1);

  if (DIM % CHUNK != 0) begin : g_bad_dim
    $error("hdc_hamming_sched: DIM must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_LAST, S_RESULT} state_t;

  state_t              state_q, state_d;
  logic                rd_en_q, rd_en_d;
  logic                vld_q, vld_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [CNT_W-1:0]    acc_h_q, acc_h_d;
  logic [CNT_W-1:0]    acc_s_q, acc_s_d;
  logic [CNT_W-1:0]    dist_h_q, dist_h_d;
  logic [CNT_W-1:0]    dist_s_q, dist_s_d;
  logic [1:0]          ham_spam_q, ham_spam_d;

  function automatic logic [PC_W-1:0] popcnt(input logic [CHUNK-1:0] v);
    logic [PC_W-1:0] c;
    c = '0;
    for (int i = 0; i < CHUNK; i++) begin
      c = c + PC_W'(v[i]);
    end
    return c;
  endfunction

  always_comb begin
    state_d    = state_q;
    rd_en_d    = 1'b0;
    vld_d      = rd_en_q;
    addr_d     = addr_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    acc_h_d    = acc_h_q;
    acc_s_d    = acc_s_q;
    dist_h_d   = dist_h_q;
    dist_s_d   = dist_s_q;
    ham_spam_d = ham_spam_q;

    // Chunk data is only looked at when a read was issued the previous cycle.
    if (vld_q) begin
      acc_h_d = acc_h_q + CNT_W'(popcnt(q_chunk ^ ham_chunk));
      acc_s_d = acc_s_q + CNT_W'(popcnt(q_chunk ^ spam_chunk));
    end

    case (state_q)
      S_IDLE: begin
        busy_d = start;
        if (start) begin
          acc_h_d = '0;
          acc_s_d = '0;
          rd_en_d = 1'b1;
          addr_d  = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (addr_q == ADDR_W'(N_CHK - 1)) begin
          state_d = S_LAST;
        end else begin
          rd_en_d = 1'b1;
          addr_d  = addr_q + 1'b1;
        end
      end
      S_LAST: begin
        state_d = S_RESULT;
      end
      S_RESULT: begin
        dist_h_d = acc_h_q;
        dist_s_d = acc_s_q;
        if (acc_h_q < acc_s_q) begin
          ham_spam_d = 2'b01;
        end else if (acc_h_q > acc_s_q) begin
          ham_spam_d = 2'b11;
        end else begin
          ham_spam_d = 2'b00;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rd_en_q    <= 1'b0;
      vld_q      <= 1'b0;
      addr_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      acc_h_q    <= '0;
      acc_s_q    <= '0;
      dist_h_q   <= '0;
      dist_s_q   <= '0;
      ham_spam_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      rd_en_q    <= rd_en_d;
      vld_q      <= vld_d;
      addr_q     <= addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      acc_h_q    <= acc_h_d;
      acc_s_q    <= acc_s_d;
      dist_h_q   <= dist_h_d;
      dist_s_q   <= dist_s_d;
      ham_spam_q <= ham_spam_d;
    end
  end

  assign rd_en      = rd_en_q;
  assign chunk_addr = addr_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign distHam    = dist_h_q;
  assign distSpam   = dist_s_q;
  assign hamSpam    = ham_spam_q;

endmodule

// File: tb/tb_hdc_hamming_sched.sv
// tb/tb_hdc_hamming_sched.sv - directed-vector bench for hdc_hamming_sched.
module tb_hdc_hamming_sched;

  localparam int DIM    = 10000;
  localparam int CHUNK  = 100;
  localparam int N_CHK  = 100;
  localparam int ADDR_W = 7;
  localparam int CNT_W  = 14;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              rd_en;
  logic [ADDR_W-1:0] chunk_addr;
  logic [CHUNK-1:0]  q_chunk, ham_chunk, spam_chunk;
  logic              busy, done;
  logic [CNT_W-1:0]  distHam, distSpam;
  logic [1:0]        hamSpam;

  hdc_hamming_sched #(.DIM(DIM), .CHUNK(CHUNK)) dut (
    .clk(clk), .rst(rst), .start(start), .rd_en(rd_en), .chunk_addr(chunk_addr),
    .q_chunk(q_chunk), .ham_chunk(ham_chunk), .spam_chunk(spam_chunk),
    .busy(busy), .done(done), .distHam(distHam), .distSpam(distSpam), .hamSpam(hamSpam)
  );

  always #5 clk = ~clk;

  logic [CHUNK-1:0] q_mem [N_CHK];
  logic [CHUNK-1:0] h_mem [N_CHK];
  logic [CHUNK-1:0] s_mem [N_CHK];
  int               hits [N_CHK];
  int               bad_addr;
  logic             clr_hits = 1'b0;

  // Chunk memories with one-cycle read latency; X when no read is outstanding.
  always @(posedge clk) begin
    if (rd_en) begin
      q_chunk    <= q_mem[chunk_addr];
      ham_chunk  <= h_mem[chunk_addr];
      spam_chunk <= s_mem[chunk_addr];
    end else begin
      q_chunk    <= 'x;
      ham_chunk  <= 'x;
      spam_chunk <= 'x;
    end
    if (clr_hits) begin
      for (int c = 0; c < N_CHK; c++) hits[c] <= 0;
      bad_addr <= 0;
    end else if (rd_en) begin
      if (int'(chunk_addr) < N_CHK) hits[chunk_addr] <= hits[chunk_addr] + 1;
      else bad_addr <= bad_addr + 1;
    end
  end

  typedef struct {
    int kind;
    int eh;
    int es;
    int ed;
  } vec_t;

  vec_t tbl [6];
  int total = 0;
  int bad   = 0;
  int busy_at_done, busy_after;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic load(input int kind);
    logic [127:0] tmp;
    logic [CHUNK-1:0] m;
    for (int c = 0; c < N_CHK; c++) begin
      tmp = {$urandom, $urandom, $urandom, $urandom};
      q_mem[c] = tmp[CHUNK-1:0];
      h_mem[c] = q_mem[c];
      s_mem[c] = q_mem[c];
    end
    case (kind)
      0: for (int c = 0; c < N_CHK; c++) s_mem[c] = ~q_mem[c];
      1: h_mem[5] = ~q_mem[5];
      2: begin
        h_mem[0][0]  = ~q_mem[0][0];
        s_mem[99][99] = ~q_mem[99][99];
      end
      3: for (int c = 0; c < N_CHK; c++) h_mem[c] = ~q_mem[c];
      4: begin
        m = 100'hFF;
        h_mem[3]  = q_mem[3] ^ m;
        s_mem[10] = q_mem[10] ^ m;
        s_mem[20] = q_mem[20] ^ m;
      end
      default: begin
        m = (100'd1 << 37) - 100'd1;
        h_mem[7] = q_mem[7] ^ m;
        s_mem[7] = q_mem[7] ^ m;
      end
    endcase
  endtask

  task automatic clear_hits();
    @(negedge clk) clr_hits = 1'b1;
    @(negedge clk) clr_hits = 1'b0;
  endtask

  task automatic check_hits(input string nm);
    int wrong = 0;
    for (int c = 0; c < N_CHK; c++) if (hits[c] != 1) wrong++;
    chk({nm, "_addr_once"}, wrong, 0);
    chk({nm, "_addr_range"}, bad_addr, 0);
  endtask

  // Starts a run, optionally re-pulses start at cycles pa/pb, watches 150 cycles.
  task automatic run_seq(input int pa, input int pb, output int lat, output int ndone);
    lat = -1;
    ndone = 0;
    busy_at_done = -1;
    busy_after = -1;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 150; cyc++) begin
      @(negedge clk) start = (cyc == pa || cyc == pb);
      @(posedge clk);
      #1;
      if (lat > 0 && cyc == lat + 1) busy_after = int'(busy);
      if (done) begin
        ndone++;
        if (lat < 0) begin
          lat = cyc;
          busy_at_done = int'(busy);
        end
      end
    end
  endtask

  task automatic check_result(input string nm, input int eh, input int es, input int ed);
    chk({nm, "_distHam"}, int'(distHam), eh);
    chk({nm, "_distSpam"}, int'(distSpam), es);
    chk({nm, "_hamSpam"}, int'(hamSpam), ed);
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_rd_en"}, int'(rd_en), 0);
    chk({nm, "_busy"}, int'(busy), 0);
    chk({nm, "_done"}, int'(done), 0);
    chk({nm, "_addr"}, int'(chunk_addr), 0);
    check_result(nm, 0, 0, 0);
  endtask

  initial begin
    int lat, nd, found, r, cyc, prev, hold_bad;
    int hk [3];
    int hh [3];
    int hs [3];
    int hd [3];

    tbl[0] = '{kind: 0, eh: 0,     es: 10000, ed: 1};
    tbl[1] = '{kind: 1, eh: 100,   es: 0,     ed: 3};
    tbl[2] = '{kind: 2, eh: 1,     es: 1,     ed: 0};
    tbl[3] = '{kind: 3, eh: 10000, es: 0,     ed: 3};
    tbl[4] = '{kind: 4, eh: 8,     es: 16,    ed: 1};
    tbl[5] = '{kind: 5, eh: 37,    es: 37,    ed: 0};
    hk = '{1, 2, 5};
    hh = '{100, 1, 37};
    hs = '{0, 1, 37};
    hd = '{3, 0, 0};

    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      load(tbl[i].kind);
      clear_hits();
      run_seq(-1, -1, lat, nd);
      chk($sformatf("vec%0d_latency", i), lat, 102);
      chk($sformatf("vec%0d_ndone", i), nd, 1);
      chk($sformatf("vec%0d_busy_at_done", i), busy_at_done, 1);
      chk($sformatf("vec%0d_busy_after", i), busy_after, 0);
      check_result($sformatf("vec%0d", i), tbl[i].eh, tbl[i].es, tbl[i].ed);
      check_hits($sformatf("vec%0d", i));
    end

    // start pulses while busy are dropped
    load(1);
    clear_hits();
    run_seq(1, 50, lat, nd);
    chk("ignore_latency", lat, 102);
    chk("ignore_ndone", nd, 1);
    check_result("ignore", 100, 0, 3);
    check_hits("ignore");

    // reset in the middle of a run
    load(3);
    clear_hits();
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    found = 0;
    for (int k = 0; k < 200 && found == 0; k++) begin
      @(posedge clk);
      #1;
      if (chunk_addr == 7'd50) found = 1;
    end
    chk("abort_reached_50", found, 1);
    rst = 1'b1;
    #1;
    check_zero("abort");
    @(negedge clk) rst = 1'b0;
    nd = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (done) nd++;
    end
    chk("abort_no_done", nd, 0);
    load(4);
    clear_hits();
    run_seq(-1, -1, lat, nd);
    chk("restart_latency", lat, 102);
    check_result("restart", 8, 16, 1);
    check_hits("restart");

    // start held high: back-to-back runs with fresh vectors each time
    load(hk[0]);
    @(negedge clk) start = 1'b1;
    r = 0;
    cyc = 0;
    prev = 0;
    hold_bad = 0;
    while (r < 3 && cyc < 400) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done) begin
        check_result($sformatf("held%0d", r), hh[r], hs[r], hd[r]);
        if (r > 0) chk($sformatf("held%0d_period", r), cyc - prev, 103);
        prev = cyc;
        r++;
        if (r < 3) load(hk[r]);
      end else if (r > 0) begin
        if (int'(distHam) != hh[r-1] || int'(distSpam) != hs[r-1] || int'(hamSpam) != hd[r-1])
          hold_bad++;
      end
    end
    @(negedge clk) start = 1'b0;
    chk("held_runs", r, 3);
    chk("held_hold", hold_bad, 0);
    repeat (110) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
